// File: rtl/anita_scaler_gate_scheduler.sv
// anita_scaler_gate_scheduler: gates per-line scaler edge counters into windows and serves the latched bank.
module anita_scaler_gate_scheduler #(
    parameter int NUM_SCALERS   = 32,
    parameter int CNT_WIDTH     = 16,
    parameter int PERIOD_CYCLES = 33333
) (
    input  logic                   mclk_i,
    input  logic                   rst_i,
    input  logic [NUM_SCALERS-1:0] scal_i,
    input  logic [NUM_SCALERS-1:0] mask_i,
    input  logic                   ref_pulse_i,
    input  logic                   use_ref_i,
    input  logic                   rd_req_i,
    input  logic [4:0]             rd_addr_i,
    output logic                   rd_ack_o,
    output logic [CNT_WIDTH-1:0]   rd_data_o,
    output logic                   data_ready_o,
    output logic                   overflow_o,
    output logic [7:0]             window_o
);
    typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;
    state_t state, state_nx;
    logic [31:0] timer;
    logic ref_prev, bnd, rd_last, latch;
    logic [NUM_SCALERS-1:0] prev, rise;
    logic [CNT_WIDTH-1:0] cnt [NUM_SCALERS];
    logic [CNT_WIDTH-1:0] bank [NUM_SCALERS];
    assign rise    = scal_i & ~prev & ~mask_i;
    assign latch   = state == LATCH;
    assign rd_last = rd_req_i && rd_addr_i == 5'(NUM_SCALERS-1);
    always_comb begin
        bnd = !latch && (use_ref_i ? (ref_pulse_i && !ref_prev) : (timer == 32'(PERIOD_CYCLES-1)));
        state_nx = latch ? COUNT : bnd ? (state == IDLE ? COUNT : LATCH) : state;
    end
    always_ff @(posedge mclk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge mclk_i or posedge rst_i) begin
        if (rst_i) begin
            timer        <= '0;
            ref_prev     <= 1'b0;
            prev         <= '0;
            rd_ack_o     <= 1'b0;
            rd_data_o    <= '0;
            data_ready_o <= 1'b0;
            overflow_o   <= 1'b0;
            window_o     <= '0;
        end else begin
            timer        <= bnd ? '0 : latch ? timer : timer + 32'd1;
            ref_prev     <= ref_pulse_i;
            prev         <= scal_i;
            rd_ack_o     <= rd_req_i;
            if (rd_req_i) rd_data_o <= int'(rd_addr_i) < NUM_SCALERS ? bank[rd_addr_i] : '0;
            data_ready_o <= latch ? 1'b1 : rd_last ? 1'b0 : data_ready_o;
            overflow_o   <= latch ? (overflow_o | data_ready_o) : rd_last ? 1'b0 : overflow_o;
            if (latch) window_o <= window_o + 8'd1;
        end
    end
    // the edge seen in the latch cycle seeds the next window so no pulse is lost
    always_ff @(posedge mclk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_SCALERS; n++) begin
                cnt[n]  <= '0;
                bank[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_SCALERS; n++) begin
                if (latch) begin
                    bank[n] <= cnt[n];
                    cnt[n]  <= CNT_WIDTH'(rise[n]);
                end else if (state == COUNT && rise[n] && cnt[n] != '1) begin
                    cnt[n] <= cnt[n] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_anita_scaler_gate_scheduler.sv
// tb_anita_scaler_gate_scheduler: scoreboard bench for the scaler gate scheduler.
module tb_anita_scaler_gate_scheduler;
    logic mclk_i = 1'b0;
    logic rst_i;
    logic [31:0] scal_i, mask_i;
    logic ref_pulse_i, use_ref_i, rd_req_i;
    logic [4:0] rd_addr_i;
    logic rd_ack_o, data_ready_o, overflow_o;
    logic [7:0] rd_data_o, window_o;
    int errors = 0;
    int checks = 0;
    int cy = 0;
    logic tog = 1'b0;
    logic rq, rs;
    logic [31:0] q [$];

    anita_scaler_gate_scheduler #(.NUM_SCALERS(32), .CNT_WIDTH(8), .PERIOD_CYCLES(100)) dut (
        .mclk_i(mclk_i), .rst_i(rst_i), .scal_i(scal_i), .mask_i(mask_i),
        .ref_pulse_i(ref_pulse_i), .use_ref_i(use_ref_i), .rd_req_i(rd_req_i),
        .rd_addr_i(rd_addr_i), .rd_ack_o(rd_ack_o), .rd_data_o(rd_data_o),
        .data_ready_o(data_ready_o), .overflow_o(overflow_o), .window_o(window_o)
    );

    always #5 mclk_i = ~mclk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk_i);
        #1;
        cy++;
        if (tog) scal_i[0] = ~scal_i[0];
    endtask

    task automatic run_to(input int n);
        while (cy < n) tick();
    endtask

    task automatic rd(input int a, input int exp);
        rd_req_i  = 1'b1;
        rd_addr_i = 5'(a);
        q.push_back(32'(exp));
        tick();
        rd_req_i  = 1'b0;
    endtask

    task automatic pulses(input int ch_a, input int n_a, input int ch_b, input int n_b);
        for (int k = 0; k < 10; k++) begin
            scal_i[ch_a] = k < n_a;
            scal_i[ch_b] = k < n_b;
            tick();
            scal_i[ch_a] = 1'b0;
            scal_i[ch_b] = 1'b0;
            tick();
        end
    endtask

    task automatic ref_at(input int n);
        run_to(n);
        ref_pulse_i = 1'b1;
        tick();
        ref_pulse_i = 1'b0;
    endtask

    // every read request must be acked exactly one cycle later with the queued value
    always begin
        @(posedge mclk_i);
        rq = rd_req_i;
        rs = rst_i;
        #1;
        if (!rs && !rst_i && (rq || rd_ack_o)) begin
            check("ack_latency", 32'(rd_ack_o), 32'(rq));
            if (rd_ack_o) begin
                if (q.size() == 0) check("ack_unexpected", 32'(rd_ack_o), 32'd0);
                else check("rd_data", 32'(rd_data_o), q.pop_front());
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        scal_i = '0; mask_i = '0; ref_pulse_i = 1'b0; use_ref_i = 1'b0;
        rd_req_i = 1'b0; rd_addr_i = '0;
        repeat (3) @(posedge mclk_i);
        #1;
        check("rst_ack", 32'(rd_ack_o), 0);
        check("rst_data", 32'(rd_data_o), 0);
        check("rst_ready", 32'(data_ready_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        check("rst_window", 32'(window_o), 0);
        rst_i = 1'b0;
        cy = 0;
        run_to(110);
        pulses(3, 10, 4, 7);
        run_to(195);
        check("no_latch_before_first_window", 32'(window_o), 0);
        run_to(210);
        rd(3, 10);
        rd(4, 7);
        check("window1", 32'(window_o), 1);
        check("ready1", 32'(data_ready_o), 1);
        check("ovf1", 32'(overflow_o), 0);
        mask_i[3] = 1'b1;
        run_to(220);
        pulses(3, 10, 4, 7);
        run_to(301);
        scal_i[5] = 1'b1;
        tick();
        scal_i[5] = 1'b0;
        run_to(305);
        check("window2", 32'(window_o), 2);
        check("ovf2", 32'(overflow_o), 1);
        check("ready2", 32'(data_ready_o), 1);
        run_to(310);
        rd(3, 0);
        rd(4, 7);
        rd(5, 0);
        run_to(320);
        pulses(5, 3, 5, 3);
        run_to(402);
        rd(5, 0);
        rd(5, 4);
        run_to(406);
        check("rd_data_hold", 32'(rd_data_o), 4);
        check("window3", 32'(window_o), 3);
        run_to(419);
        check("ovf3", 32'(overflow_o), 1);
        run_to(420);
        for (int a = 0; a < 32; a++) rd(a, a == 5 ? 4 : 0);
        check("ready_cleared", 32'(data_ready_o), 0);
        check("ovf_cleared", 32'(overflow_o), 0);
        run_to(460);
        use_ref_i = 1'b1;
        ref_at(480);
        run_to(481);
        tog = 1'b1;
        run_to(485);
        check("window_ref1", 32'(window_o), 4);
        run_to(900);
        check("timer_idle_in_ref_mode", 32'(window_o), 4);
        ref_at(980);
        run_to(990);
        rd(0, 250);
        check("window_ref2", 32'(window_o), 5);
        ref_at(1480);
        run_to(1490);
        rd(0, 250);
        check("window_ref3", 32'(window_o), 6);
        ref_at(2280);
        run_to(2290);
        rd(0, 255);
        ref_at(2480);
        run_to(2490);
        rd(0, 100);
        check("window_ref5", 32'(window_o), 8);
        run_to(2500);
        tog = 1'b0;
        rd_req_i = 1'b1;
        rd_addr_i = '0;
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_window", 32'(window_o), 0);
        check("async_rst_ready", 32'(data_ready_o), 0);
        check("async_rst_data", 32'(rd_data_o), 0);
        check("async_rst_ack", 32'(rd_ack_o), 0);
        tick();
        check("rst_drops_ack", 32'(rd_ack_o), 0);
        rd_req_i = 1'b0;
        rst_i = 1'b0;
        tick();
        tick();
        check("post_rst_window", 32'(window_o), 0);
        check("sb_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/anita_scaler_gate_scheduler.md
Name: anita_scaler_gate_scheduler

Overview:
- Sequences the counting windows of the L0/L1/L2 scaler pulse outputs of the TURF trigger processor.
- Counts the rising edge of each scaler line over a gate window. The window boundary comes from REF_PULSE or from an internal period timer.
- At each boundary, copies all counts into a holding bank and restarts counting.
- Serves the holding bank to the scaler readout logic through a request/acknowledge read port. Sits between the processor scal_o bus and the register interface.

Parameters:
NUM_SCALERS, 32, number of scaler input lines (address width 5)
CNT_WIDTH, 16, counter and readout data width
PERIOD_CYCLES, 33333, internal gate period in mclk_i cycles (1 ms at 33 MHz)

Ports:
mclk_i  input  1  master 33 MHz clock
rst_i  input  1  asynchronous reset, active-high
scal_i  input  NUM_SCALERS  scaler pulse lines, synchronous to mclk_i
mask_i  input  NUM_SCALERS  1 = channel forced to count zero
ref_pulse_i  input  1  TURF reference pulse, registered to mclk_i upstream
use_ref_i  input  1  1 = gate on ref_pulse_i rising edge, 0 = internal timer
rd_req_i  input  1  single-cycle read request
rd_addr_i  input  5  scaler index to read
rd_ack_o  output  1  read acknowledge, one cycle
rd_data_o  output  CNT_WIDTH  holding-bank value
data_ready_o  output  1  new holding bank not yet fully read
overflow_o  output  1  bank overwritten before it was fully read
window_o  output  8  latched-window count, wraps at 255

Behaviour:
- Reset (async): all outputs 0; counters, bank, edge registers, and timer 0; state IDLE.
- State machine:
  - IDLE: no counting; waits for the first boundary, then goes to COUNT (no latch on this first boundary).
  - COUNT: counts; on boundary goes to LATCH.
  - LATCH: one cycle; returns to COUNT.
- Boundary: use_ref_i=1 -> cycle where ref_pulse_i=1 and the previous sample=0. use_ref_i=0 -> timer==PERIOD_CYCLES-1.
- Timer: increments every cycle outside LATCH; clears on every boundary.
- use_ref_i change takes effect on the next cycle; the timer keeps running regardless.
- Edge: scal_i[n]=1 and prev[n]=0 and mask_i[n]=0. prev updates every cycle in every state.
- In COUNT, an edge increments cnt[n]. cnt saturates at 2^CNT_WIDTH-1 and does not wrap.
- In LATCH:
  - bank[n] <= cnt[n], using the value before this cycle's edge.
  - cnt[n] <= 1 if an edge occurs this cycle, else 0. No edge is lost.
  - window_o increments.
  - data_ready_o <= 1.
  - overflow_o <= 1 if data_ready_o was already 1.
- A boundary that occurs during the LATCH cycle is ignored.
- Read: rd_req_i sampled at edge k. At edge k+1, rd_ack_o=1 and rd_data_o=bank[rd_addr_i] as held before edge k. A request coincident with LATCH therefore returns the old bank.
- rd_data_o holds its value until the next ack.
- Back-to-back requests are allowed, one per cycle, each acked one cycle later.
- Addresses >= NUM_SCALERS return 0 and are acked.
- Acked read of address NUM_SCALERS-1 clears data_ready_o and overflow_o, unless a LATCH sets them in the same cycle (set wins).
- Reset mid-window or mid-read: immediate return to reset values; any pending ack is dropped.

Test Plan:
- PERIOD_CYCLES=100, use_ref_i=0: 10 pulses on scal_i[3] in the first full window; read addr 3 -> rd_ack_o one cycle after rd_req_i, rd_data_o=10, window_o=1, data_ready_o=1.
- mask_i[3]=1 during the same stimulus -> bank[3]=0; unmasked channel 4 with 7 pulses -> 7.
- use_ref_i=1, ref pulses 500 cycles apart, scal_i[0] toggling every 2 cycles -> bank[0]=250 each window; the internal timer never latches.
- Pulse on scal_i[5] exactly in the LATCH cycle -> that window's bank[5] excludes it; the next window's bank[5] includes it (count = 1 + subsequent edges).
- 70000 edges in one window with PERIOD_CYCLES=200000 -> bank=65535 (saturated); the next window counts from 0 or 1.
- Two windows latched with no reads -> overflow_o=1. Read addresses 0..31 -> after the ack of addr 31, data_ready_o=0 and overflow_o=0. rd_req_i coincident with LATCH -> old value returned. Assert rst_i mid-window -> all outputs 0 within the same cycle.
